// File: rtl/sc_scratchpad_pkg.sv
// Shared constants for the scratchpad register file: IR field positions,
// index derivation helpers and register names for the default configuration.
package sc_scratchpad_pkg;

  localparam int OP_HI     = 31;
  localparam int OP_LO     = 30;
  localparam int RD_HI     = 29;
  localparam int RD_LO     = 25;
  localparam int OP2_HI    = 24;
  localparam int OP2_LO    = 22;
  localparam int OP3_HI    = 24;
  localparam int OP3_LO    = 19;
  localparam int RS1_HI    = 18;
  localparam int RS1_LO    = 14;
  localparam int I_BIT     = 13;
  localparam int RS2_HI    = 4;
  localparam int RS2_LO    = 0;
  localparam int SIMM13_HI = 12;
  localparam int SIMM13_LO = 0;

  function automatic int idx_pc(input int num_general);
    return num_general;
  endfunction

  function automatic int idx_temp0(input int num_general);
    return num_general + 1;
  endfunction

  function automatic int idx_ir(input int num_general, input int num_temp);
    return num_general + num_temp + 1;
  endfunction

  function automatic int num_entries(input int num_general, input int num_temp);
    return idx_ir(num_general, num_temp) + 1;
  endfunction

  // Register names for NUM_GENERAL=32, NUM_TEMP=4
  localparam int R0    = 0;
  localparam int PC    = 32;
  localparam int TEMP0 = 33;
  localparam int TEMP1 = 34;
  localparam int TEMP2 = 35;
  localparam int TEMP3 = 36;
  localparam int IR    = 37;

endpackage

// File: rtl/sc_scratchpad_readport.sv
// One combinational read port: index-to-data mux with optional forwarding
// of the write that is about to commit this cycle.
module sc_scratchpad_readport
  import sc_scratchpad_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 32,
  parameter int NUM_ENTRIES   = 38,
  parameter int ADDRW         = 6,
  parameter int BYPASS        = 1
) (
  input  logic [DATAWIDTH_BUS-1:0] entries_i [NUM_ENTRIES],
  input  logic [ADDRW-1:0]         rd_addr_i,
  input  logic                     wr_fwd_i,
  input  logic [ADDRW-1:0]         wr_addr_i,
  input  logic [DATAWIDTH_BUS-1:0] wr_data_i,
  output logic [DATAWIDTH_BUS-1:0] rd_data_o,
  output logic                     rd_err_o
);

  logic in_range;

  assign in_range = int'(rd_addr_i) < NUM_ENTRIES;
  assign rd_err_o = !in_range;

  // wr_fwd_i already excludes r0, out-of-range indices and reset cycles
  always_comb begin
    rd_data_o = '0;
    if (in_range) begin
      rd_data_o = entries_i[rd_addr_i];
      if ((BYPASS != 0) && wr_fwd_i && (wr_addr_i == rd_addr_i)) begin
        rd_data_o = wr_data_i;
      end
    end
  end

endmodule

// File: rtl/sc_scratchpad_regfile.sv
// ARC-style scratchpad register file: r0 constant, general registers, PC with
// auto-increment, temporaries and IR in one address space; 2 read, 1 write port.
module sc_scratchpad_regfile
  import sc_scratchpad_pkg::*;
#(
  parameter int                       DATAWIDTH_BUS        = 32,
  parameter int                       NUM_GENERAL          = 32,
  parameter int                       NUM_TEMP             = 4,
  parameter logic [DATAWIDTH_BUS-1:0] DATA_REGFIXED_INIT_0 = '0,
  parameter logic [DATAWIDTH_BUS-1:0] PC_RESET             = '0,
  parameter int                       PC_STEP              = 4,
  parameter int                       BYPASS               = 1,
  localparam int IDX_PC      = idx_pc(NUM_GENERAL),
  localparam int IDX_TEMP0   = idx_temp0(NUM_GENERAL),
  localparam int IDX_IR      = idx_ir(NUM_GENERAL, NUM_TEMP),
  localparam int NUM_ENTRIES = num_entries(NUM_GENERAL, NUM_TEMP),
  localparam int ADDRW       = $clog2(NUM_ENTRIES)
) (
  input  logic                     uDataPath_CLOCK_50,
  input  logic                     uDataPath_RESET_InHigh,
  input  logic [ADDRW-1:0]         SC_Scratchpad_WriteAddr,
  input  logic                     SC_Scratchpad_Write_InLow,
  input  logic [DATAWIDTH_BUS-1:0] SC_Scratchpad_DataBUS_In,
  input  logic                     SC_Scratchpad_PC_Inc,
  input  logic [ADDRW-1:0]         SC_Scratchpad_ReadAddrA,
  input  logic [ADDRW-1:0]         SC_Scratchpad_ReadAddrB,
  output logic [DATAWIDTH_BUS-1:0] SC_Scratchpad_DataBUS_OutA,
  output logic [DATAWIDTH_BUS-1:0] SC_Scratchpad_DataBUS_OutB,
  output logic [DATAWIDTH_BUS-1:0] SC_Scratchpad_PC_Out,
  output logic [1:0]               SC_Scratchpad_IR_Op,
  output logic [4:0]               SC_Scratchpad_IR_Rd,
  output logic [2:0]               SC_Scratchpad_IR_Op2,
  output logic [5:0]               SC_Scratchpad_IR_Op3,
  output logic [4:0]               SC_Scratchpad_IR_Rs1,
  output logic                     SC_Scratchpad_IR_I,
  output logic [4:0]               SC_Scratchpad_IR_Rs2,
  output logic [12:0]              SC_Scratchpad_IR_Simm13,
  output logic                     SC_Scratchpad_AddrErr
);

  // r0 is not stored; the PC slot of regs_q stays at reset value, pc_q holds the PC
  logic [DATAWIDTH_BUS-1:0] regs_q [1:NUM_ENTRIES-1];
  logic [DATAWIDTH_BUS-1:0] pc_q, pc_d;
  logic                     addr_err_q, addr_err_d;
  logic [DATAWIDTH_BUS-1:0] entries [NUM_ENTRIES];
  logic [DATAWIDTH_BUS-1:0] ir;
  logic                     wr_req, wr_in_range, wr_commit, wr_is_pc;
  logic                     rd_err_a, rd_err_b;

  assign wr_req      = !SC_Scratchpad_Write_InLow && !uDataPath_RESET_InHigh;
  assign wr_in_range = int'(SC_Scratchpad_WriteAddr) < NUM_ENTRIES;
  assign wr_commit   = wr_req && wr_in_range && (SC_Scratchpad_WriteAddr != '0);
  assign wr_is_pc    = int'(SC_Scratchpad_WriteAddr) == IDX_PC;

  always_comb begin
    pc_d = pc_q;
    if (wr_commit && wr_is_pc) begin
      pc_d = SC_Scratchpad_DataBUS_In;
    end else if (SC_Scratchpad_PC_Inc) begin
      pc_d = pc_q + DATAWIDTH_BUS'(PC_STEP);
    end
  end

  assign addr_err_d = addr_err_q || rd_err_a || rd_err_b || (wr_req && !wr_in_range);

  always_ff @(posedge uDataPath_CLOCK_50) begin
    if (uDataPath_RESET_InHigh) begin
      for (int i = 1; i < NUM_ENTRIES; i++) begin
        regs_q[i] <= '0;
      end
      pc_q       <= PC_RESET;
      addr_err_q <= 1'b0;
    end else begin
      if (wr_commit && !wr_is_pc) begin
        regs_q[SC_Scratchpad_WriteAddr] <= SC_Scratchpad_DataBUS_In;
      end
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    entries[0] = DATA_REGFIXED_INIT_0;
    for (int i = 1; i < NUM_ENTRIES; i++) begin
      entries[i] = (i == IDX_PC) ? pc_q : regs_q[i];
    end
  end

  sc_scratchpad_readport #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS), .NUM_ENTRIES(NUM_ENTRIES), .ADDRW(ADDRW), .BYPASS(BYPASS)
  ) u_port_a (
    .entries_i (entries),
    .rd_addr_i (SC_Scratchpad_ReadAddrA),
    .wr_fwd_i  (wr_commit),
    .wr_addr_i (SC_Scratchpad_WriteAddr),
    .wr_data_i (SC_Scratchpad_DataBUS_In),
    .rd_data_o (SC_Scratchpad_DataBUS_OutA),
    .rd_err_o  (rd_err_a)
  );

  sc_scratchpad_readport #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS), .NUM_ENTRIES(NUM_ENTRIES), .ADDRW(ADDRW), .BYPASS(BYPASS)
  ) u_port_b (
    .entries_i (entries),
    .rd_addr_i (SC_Scratchpad_ReadAddrB),
    .wr_fwd_i  (wr_commit),
    .wr_addr_i (SC_Scratchpad_WriteAddr),
    .wr_data_i (SC_Scratchpad_DataBUS_In),
    .rd_data_o (SC_Scratchpad_DataBUS_OutB),
    .rd_err_o  (rd_err_b)
  );

  assign ir                      = regs_q[IDX_IR];
  assign SC_Scratchpad_PC_Out    = pc_q;
  assign SC_Scratchpad_AddrErr   = addr_err_q;
  assign SC_Scratchpad_IR_Op     = ir[OP_HI:OP_LO];
  assign SC_Scratchpad_IR_Rd     = ir[RD_HI:RD_LO];
  assign SC_Scratchpad_IR_Op2    = ir[OP2_HI:OP2_LO];
  assign SC_Scratchpad_IR_Op3    = ir[OP3_HI:OP3_LO];
  assign SC_Scratchpad_IR_Rs1    = ir[RS1_HI:RS1_LO];
  assign SC_Scratchpad_IR_I      = ir[I_BIT];
  assign SC_Scratchpad_IR_Rs2    = ir[RS2_HI:RS2_LO];
  assign SC_Scratchpad_IR_Simm13 = ir[SIMM13_HI:SIMM13_LO];

endmodule

// File: tb/tb_sc_scratchpad_regfile.sv
// Bench for sc_scratchpad_regfile: a forwarding and a non-forwarding instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_sc_scratchpad_regfile;

  localparam int N        = 38;
  localparam int IDX_PC   = 32;
  localparam int IDX_IR   = 37;
  localparam logic [31:0] R0_CONST = 32'hC0FFEE00;
  localparam logic [31:0] PC_RST   = 32'h0000_0100;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_n, inc;
  logic [5:0]  wa, ra, rb;
  logic [31:0] din;

  logic [31:0] a1, b1, pc1, a0, b0, pc0;
  logic [1:0]  op1, op0;
  logic [4:0]  rd1, rd0, rs1_1, rs1_0, rs2_1, rs2_0;
  logic [2:0]  op2_1, op2_0;
  logic [5:0]  op3_1, op3_0;
  logic        i1, i0, err1, err0;
  logic [12:0] simm1, simm0;

  sc_scratchpad_regfile #(
    .DATA_REGFIXED_INIT_0(R0_CONST), .PC_RESET(PC_RST), .BYPASS(1)
  ) dut_byp (
    .uDataPath_CLOCK_50(clk), .uDataPath_RESET_InHigh(rst),
    .SC_Scratchpad_WriteAddr(wa), .SC_Scratchpad_Write_InLow(wr_n),
    .SC_Scratchpad_DataBUS_In(din), .SC_Scratchpad_PC_Inc(inc),
    .SC_Scratchpad_ReadAddrA(ra), .SC_Scratchpad_ReadAddrB(rb),
    .SC_Scratchpad_DataBUS_OutA(a1), .SC_Scratchpad_DataBUS_OutB(b1),
    .SC_Scratchpad_PC_Out(pc1), .SC_Scratchpad_IR_Op(op1), .SC_Scratchpad_IR_Rd(rd1),
    .SC_Scratchpad_IR_Op2(op2_1), .SC_Scratchpad_IR_Op3(op3_1), .SC_Scratchpad_IR_Rs1(rs1_1),
    .SC_Scratchpad_IR_I(i1), .SC_Scratchpad_IR_Rs2(rs2_1), .SC_Scratchpad_IR_Simm13(simm1),
    .SC_Scratchpad_AddrErr(err1)
  );

  sc_scratchpad_regfile #(
    .DATA_REGFIXED_INIT_0(R0_CONST), .PC_RESET(PC_RST), .BYPASS(0)
  ) dut_nobyp (
    .uDataPath_CLOCK_50(clk), .uDataPath_RESET_InHigh(rst),
    .SC_Scratchpad_WriteAddr(wa), .SC_Scratchpad_Write_InLow(wr_n),
    .SC_Scratchpad_DataBUS_In(din), .SC_Scratchpad_PC_Inc(inc),
    .SC_Scratchpad_ReadAddrA(ra), .SC_Scratchpad_ReadAddrB(rb),
    .SC_Scratchpad_DataBUS_OutA(a0), .SC_Scratchpad_DataBUS_OutB(b0),
    .SC_Scratchpad_PC_Out(pc0), .SC_Scratchpad_IR_Op(op0), .SC_Scratchpad_IR_Rd(rd0),
    .SC_Scratchpad_IR_Op2(op2_0), .SC_Scratchpad_IR_Op3(op3_0), .SC_Scratchpad_IR_Rs1(rs1_0),
    .SC_Scratchpad_IR_I(i0), .SC_Scratchpad_IR_Rs2(rs2_0), .SC_Scratchpad_IR_Simm13(simm0),
    .SC_Scratchpad_AddrErr(err0)
  );

  // reference model state
  logic [31:0] m_mem [N];
  logic [31:0] m_pc;
  logic        m_err;
  bit          chk_en;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int a, input bit byp);
    if (a >= N) return 32'h0;
    if (byp && !rst && !wr_n && int'(wa) == a && a != 0) return din;
    if (a == 0) return R0_CONST;
    if (a == IDX_PC) return m_pc;
    return m_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < N; i++) m_mem[i] = 32'h0;
      m_pc  = PC_RST;
      m_err = 1'b0;
    end else begin
      if (int'(ra) >= N || int'(rb) >= N || (!wr_n && int'(wa) >= N)) m_err = 1'b1;
      if (!wr_n && int'(wa) == IDX_PC) m_pc = din;
      else if (inc) m_pc = m_pc + 32'd4;
      if (!wr_n && int'(wa) < N && wa != 6'd0 && int'(wa) != IDX_PC) m_mem[wa] = din;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ir;
    ir = m_mem[IDX_IR];
    check("outA_byp",   a1, exp_read(int'(ra), 1'b1));
    check("outB_byp",   b1, exp_read(int'(rb), 1'b1));
    check("outA_nobyp", a0, exp_read(int'(ra), 1'b0));
    check("outB_nobyp", b0, exp_read(int'(rb), 1'b0));
    check("pc_byp",     pc1, m_pc);
    check("pc_nobyp",   pc0, m_pc);
    check("err_byp",    {31'b0, err1}, {31'b0, m_err});
    check("err_nobyp",  {31'b0, err0}, {31'b0, m_err});
    check("ir_op",      32'(op1),   ir >> 30);
    check("ir_rd",      32'(rd1),   (ir >> 25) & 32'h1f);
    check("ir_op2",     32'(op2_1), (ir >> 22) & 32'h7);
    check("ir_op3",     32'(op3_1), (ir >> 19) & 32'h3f);
    check("ir_rs1",     32'(rs1_1), (ir >> 14) & 32'h1f);
    check("ir_i",       32'(i1),    (ir >> 13) & 32'h1);
    check("ir_rs2",     32'(rs2_1), ir & 32'h1f);
    check("ir_simm13",  32'(simm1), ir & 32'h1fff);
    check("ir_nobyp",   {op0, rd0, op2_0, op3_0, rs1_0, i0, rs2_0, simm0},
                        {op1, rd1, op2_1, op3_1, rs1_1, i1, rs2_1, simm1} | 32'h0);
  endtask

  // driver tasks
  task automatic drive(input bit r, input bit w_n, input int a_w, input logic [31:0] d,
                       input bit i, input int a_ra, input int a_rb);
    rst  = r;
    wr_n = w_n;
    wa   = 6'(a_w);
    din  = d;
    inc  = i;
    ra   = 6'(a_ra);
    rb   = 6'(a_rb);
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_en) check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int a_ra, input int a_rb);
    drive(1'b0, 1'b1, 0, 32'h0, 1'b0, a_ra, a_rb);
    cycle();
  endtask

  initial begin
    chk_en = 1'b0;
    // reset with a simultaneous write to r3 and PC_Inc: both ignored
    drive(1'b1, 1'b0, 3, 32'hAAAA5555, 1'b1, 3, 5);
    cycle();
    chk_en = 1'b1;
    cycle();
    idle(3, 5);
    idle(IDX_IR, IDX_PC);

    // r0 ignores writes
    drive(1'b0, 1'b0, 0, 32'hDEADBEEF, 1'b0, 0, 0);
    cycle();
    idle(0, 0);

    // r7 write: same-cycle with forwarding, next cycle without
    drive(1'b0, 1'b0, 7, 32'h12345678, 1'b0, 7, 7);
    cycle();
    idle(7, 7);

    // PC increments from reset value
    repeat (3) begin
      drive(1'b0, 1'b1, 0, 32'h0, 1'b1, IDX_PC, 7);
      cycle();
    end
    idle(IDX_PC, 7);

    // PC wrap and C-bus write beating PC_Inc
    drive(1'b0, 1'b0, IDX_PC, 32'hFFFFFFFC, 1'b0, IDX_PC, IDX_PC);
    cycle();
    drive(1'b0, 1'b1, 0, 32'h0, 1'b1, IDX_PC, 0);
    cycle();
    idle(IDX_PC, 0);
    drive(1'b0, 1'b0, IDX_PC, 32'h200, 1'b1, IDX_PC, 7);
    cycle();
    idle(IDX_PC, 7);

    // IR decode
    drive(1'b0, 1'b0, IDX_IR, 32'h8A10C003, 1'b0, IDX_IR, 36);
    cycle();
    idle(IDX_IR, 33);

    // out-of-range write: no state change, sticky error until reset
    drive(1'b0, 1'b0, 38, 32'h55555555, 1'b0, 7, IDX_IR);
    cycle();
    idle(7, IDX_IR);
    idle(7, IDX_PC);
    drive(1'b1, 1'b1, 0, 32'h0, 1'b0, 7, IDX_PC);
    cycle();
    idle(7, IDX_PC);

    // out-of-range read
    idle(50, 7);
    idle(7, 7);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      int a_w, a_a, a_b;
      a_w = ($urandom_range(0, 15) == 0) ? $urandom_range(38, 63) : $urandom_range(0, 37);
      a_a = ($urandom_range(0, 3) == 0) ? a_w :
            (($urandom_range(0, 40) == 0) ? $urandom_range(38, 63) : $urandom_range(0, 37));
      a_b = ($urandom_range(0, 3) == 0) ? a_a :
            (($urandom_range(0, 40) == 0) ? $urandom_range(38, 63) : $urandom_range(0, 37));
      drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), a_w, $urandom,
            ($urandom_range(0, 2) == 0), a_a, a_b);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
